result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter WIDTH, default 32, data width of checked results.
REQ-002 Parameter DEPTH, default 20, number of expected-result entries per run (DEPTH >= 1).
REQ-003 Parameter SKIP, default 1, valid beats discarded before checking starts (SKIP >= 0).
REQ-004 Derived widths: AW = max(1, clog2(DEPTH)); CW = clog2(DEPTH+1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-007 exp_we  input  1  expected-table write enable.
REQ-008 exp_addr  input  AW  table write index.
REQ-009 exp_data  input  WIDTH  expected value.
REQ-010 exp_mask  input  WIDTH  compare mask; 1 = bit checked.
REQ-011 start  input  1  begin a run.
REQ-012 result_valid  input  1  result beat qualifier.
REQ-013 result  input  WIDTH  value under check.
REQ-014 busy  output  1  high in WARMUP or CHECK.
REQ-015 done  output  1  one-cycle pulse at run completion.
REQ-016 pass_count, fail_count  output  CW each  match and mismatch tallies.
REQ-017 any_fail  output  1  sticky; set on first mismatch of a run.
REQ-018 first_fail_idx  output  AW  entry index of first mismatch.
REQ-019 first_fail_seen  output  WIDTH  result value at first mismatch.

Function
REQ-020 States: IDLE, WARMUP, CHECK, DONE. All outputs registered.
REQ-021 Table writes are accepted only in IDLE or DONE: exp_data and exp_mask are stored at exp_addr; writes in WARMUP or CHECK are ignored; addresses >= DEPTH are ignored.
REQ-022 start in IDLE or DONE: clears pass_count, fail_count, any_fail, first_fail_idx, first_fail_seen, beat index and skip counter. Next state is WARMUP if SKIP > 0, else CHECK.
REQ-023 start in WARMUP or CHECK is ignored.
REQ-024 A table write and start in the same cycle are both performed; the written entry is used in that run.
REQ-025 WARMUP: each result_valid beat increments the skip counter; the beat that makes the count reach SKIP moves to CHECK. That beat is not compared.
REQ-026 CHECK: each result_valid beat compares entry idx. match = ((result XOR exp[idx]) AND mask[idx]) == 0.
REQ-027 On a match, pass_count increments; otherwise fail_count increments.
REQ-028 On the first mismatch of a run, any_fail is set and idx and result are captured into first_fail_idx and first_fail_seen; later mismatches do not update them.
REQ-029 idx increments by 1 per checked beat. Cycles with result_valid low change nothing.
REQ-030 On the edge that checks idx = DEPTH-1, the state moves to DONE. From the following cycle, done = 1 for exactly one cycle, with final counter values.
REQ-031 In DONE, all results hold until the next start; result_valid is ignored.
REQ-032 Counters never wrap; pass_count + fail_count = DEPTH at done.

Reset
REQ-033 reset low: state = IDLE; busy = 0, done = 0, pass_count = 0, fail_count = 0, any_fail = 0, first_fail_idx = 0, first_fail_seen = 0; idx and skip counter = 0.
REQ-034 Reset mid-run abandons the run with no done pulse. Expected-table contents are not reset and are undefined until written.
REQ-035 Release is synchronised internally; the first start is honoured on the second rising edge after reset goes high.

Verification (DEPTH=4, SKIP=1, WIDTH=32 unless noted)
REQ-036 Table {0,1,2,4}, masks all-ones; start; valid stream 0xDEAD, 0, 1, 2, 4 -> busy for 5 beats; done pulse; pass = 4, fail = 0, any_fail = 0.
REQ-037 Same table; stream 0xDEAD, 0, 1, 3, 5 -> pass = 2, fail = 2, any_fail = 1, first_fail_idx = 2, first_fail_seen = 0x00000003.
REQ-038 Entry 0 = 0x00000005 with mask 0x0000FFFF; result 0xABCD0005 at idx 0 -> counted as a pass.
REQ-039 Idle gaps of 3 cycles between valid beats, plus start pulsed during CHECK -> same final counts as REQ-036, with no restart.
REQ-040 reset low after 2 checked beats -> all outputs zero, no done pulse. After a new start and a full stream -> pass = 4.
REQ-041 SKIP=0, DEPTH=1, entry 0 = 0xFFFFFFFE; start; one beat 0xFFFFFFFE -> done pulse on the next cycle, pass = 1.

Source files
------------

// File: rtl/result_checker_if.sv
// Bus bundle for result_checker: expected-table writes, run control, result
// stream and the registered run summary.
interface result_checker_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             exp_we;
    logic [AW-1:0]    exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] exp_mask;
    logic             start;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [CW-1:0]    pass_count;
    logic [CW-1:0]    fail_count;
    logic             any_fail;
    logic [AW-1:0]    first_fail_idx;
    logic [WIDTH-1:0] first_fail_seen;

    modport master (
        output exp_we, exp_addr, exp_data, exp_mask, start, result_valid, result,
        input  busy, done, pass_count, fail_count, any_fail, first_fail_idx, first_fail_seen
    );

    modport slave (
        input  exp_we, exp_addr, exp_data, exp_mask, start, result_valid, result,
        output busy, done, pass_count, fail_count, any_fail, first_fail_idx, first_fail_seen
    );
endinterface

// File: rtl/result_checker.sv
// Compares a stream of results against a masked expected table after
// discarding SKIP warm-up beats; reports pass/fail tallies and first mismatch.
module result_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20,
    parameter int SKIP  = 1
) (
    input  logic            clk,
    input  logic            reset,
    result_checker_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CHECK, S_DONE} state_t;

    state_t           r_state;
    logic             r_rst_sync;
    logic [WIDTH-1:0] r_exp  [0:(1<<AW)-1];
    logic [WIDTH-1:0] r_mask [0:(1<<AW)-1];
    logic [AW-1:0]    r_idx;
    logic [SW-1:0]    r_skip;
    logic [CW-1:0]    r_pass;
    logic [CW-1:0]    r_fail;
    logic             r_busy;
    logic             r_done;
    logic             r_any_fail;
    logic [AW-1:0]    r_ff_idx;
    logic [WIDTH-1:0] r_ff_seen;

    logic w_rst_n;
    logic w_open;
    logic w_addr_ok;
    logic w_match;
    logic w_last;

    // Assert asynchronously, release one edge after reset rises so the
    // first start is taken on the second rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 1'b0;
        else        r_rst_sync <= 1'b1;
    end

    assign w_rst_n   = r_rst_sync;
    assign w_open    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_addr_ok = 32'(bus.exp_addr) < DEPTH;
    assign w_match   = ((bus.result ^ r_exp[r_idx]) & r_mask[r_idx]) == '0;
    assign w_last    = r_idx == AW'(DEPTH - 1);

    // Table contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.exp_we && w_open && w_addr_ok) begin
            r_exp[bus.exp_addr]  <= bus.exp_data;
            r_mask[bus.exp_addr] <= bus.exp_mask;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_skip     <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_any_fail <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_seen  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_idx      <= '0;
                        r_skip     <= '0;
                        r_pass     <= '0;
                        r_fail     <= '0;
                        r_any_fail <= 1'b0;
                        r_ff_idx   <= '0;
                        r_ff_seen  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= (SKIP > 0) ? S_WARMUP : S_CHECK;
                    end
                end
                S_WARMUP: begin
                    if (bus.result_valid) begin
                        r_skip <= r_skip + SW'(1);
                        if (r_skip == SW'(SKIP - 1)) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.result_valid) begin
                        if (w_match) begin
                            r_pass <= r_pass + CW'(1);
                        end else begin
                            r_fail <= r_fail + CW'(1);
                            if (!r_any_fail) begin
                                r_any_fail <= 1'b1;
                                r_ff_idx   <= r_idx;
                                r_ff_seen  <= bus.result;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass_count      = r_pass;
    assign bus.fail_count      = r_fail;
    assign bus.any_fail        = r_any_fail;
    assign bus.first_fail_idx  = r_ff_idx;
    assign bus.first_fail_seen = r_ff_seen;
endmodule

// File: tb/tb_result_checker.sv
// Directed and randomized checks of result_checker against a stream-level
// reference model (DEPTH=4/SKIP=1 instance plus a DEPTH=1/SKIP=0 instance).
module tb_result_checker;
    localparam int W  = 32;
    localparam int DA = 4;
    localparam int SA = 1;
    localparam int DB = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   done_a = 0;
    int   done_b = 0;

    always #5 clk = ~clk;

    result_checker_if #(.WIDTH(W), .DEPTH(DA)) ia();
    result_checker_if #(.WIDTH(W), .DEPTH(DB)) ib();

    result_checker #(.WIDTH(W), .DEPTH(DA), .SKIP(SA)) u_a (.clk(clk), .reset(reset), .bus(ia));
    result_checker #(.WIDTH(W), .DEPTH(DB), .SKIP(0))  u_b (.clk(clk), .reset(reset), .bus(ib));

    logic [31:0] m_exp  [DA];
    logic [31:0] m_mask [DA];
    logic [31:0] q_stream[$];
    int          e_pass, e_fail, e_idx;
    logic        e_any;
    logic [31:0] e_seen;

    always @(negedge clk) begin
        if (ia.done === 1'b1) done_a++;
        if (ib.done === 1'b1) done_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: drop SKIP beats, then score the next DEPTH beats against the table.
    task automatic model_run();
        e_pass = 0; e_fail = 0; e_any = 1'b0; e_idx = 0; e_seen = '0;
        for (int i = 0; i < DA; i++) begin
            logic [31:0] v;
            v = q_stream[SA + i];
            if (((v ^ m_exp[i]) & m_mask[i]) == 32'd0) e_pass++;
            else begin
                e_fail++;
                if (!e_any) begin e_any = 1'b1; e_idx = i; e_seen = v; end
            end
        end
    endtask

    task automatic wr_a(input int a, input logic [31:0] d, input logic [31:0] m, input bit with_start);
        ia.exp_we = 1'b1; ia.exp_addr = 2'(a); ia.exp_data = d; ia.exp_mask = m;
        ia.start = with_start;
        @(negedge clk);
        ia.exp_we = 1'b0; ia.start = 1'b0;
        m_exp[a] = d; m_mask[a] = m;
    endtask

    task automatic start_a();
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
    endtask

    task automatic beat_a(input logic [31:0] v);
        ia.result_valid = 1'b1; ia.result = v;
        @(negedge clk);
        ia.result_valid = 1'b0; ia.result = $urandom;
    endtask

    task automatic chk_results(input string p);
        model_run();
        chk({p, "_pass"},   32'(ia.pass_count), 32'(e_pass));
        chk({p, "_fail"},   32'(ia.fail_count), 32'(e_fail));
        chk({p, "_any"},    32'(ia.any_fail),   32'(e_any));
        chk({p, "_ffidx"},  32'(ia.first_fail_idx), 32'(e_idx));
        chk({p, "_ffseen"}, ia.first_fail_seen, e_seen);
    endtask

    // Streams q_stream with optional gaps; poke drives a start and a table
    // write during the gaps, both of which must be ignored mid-run.
    task automatic run_a(input string p, input int gap, input bit poke, input bit do_start);
        int d0;
        d0 = done_a;
        if (do_start) start_a();
        chk({p, "_busy"}, 32'(ia.busy), 32'd1);
        foreach (q_stream[k]) begin
            beat_a(q_stream[k]);
            if (k != q_stream.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke && g == 0) begin
                        ia.exp_we = 1'b1; ia.exp_addr = 2'd3;
                        ia.exp_data = 32'h5A5A_5A5A; ia.exp_mask = '1;
                    end
                    if (poke && g == 1) ia.start = 1'b1;
                    @(negedge clk);
                    ia.start = 1'b0; ia.exp_we = 1'b0;
                end
            end
        end
        chk({p, "_done"},    32'(ia.done), 32'd1);
        chk({p, "_busyend"}, 32'(ia.busy), 32'd0);
        @(negedge clk);
        chk({p, "_donelow"}, 32'(ia.done), 32'd0);
        @(negedge clk);
        chk({p, "_donecnt"}, 32'(done_a - d0), 32'd1);
        chk_results(p);
    endtask

    initial begin
        ia.exp_we = 0; ia.exp_addr = 0; ia.exp_data = 0; ia.exp_mask = 0;
        ia.start = 0; ia.result_valid = 0; ia.result = 0;
        ib.exp_we = 0; ib.exp_addr = 0; ib.exp_data = 0; ib.exp_mask = 0;
        ib.start = 0; ib.result_valid = 0; ib.result = 0;

        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(ia.busy), 32'd0);
        chk("rst_done",   32'(ia.done), 32'd0);
        chk("rst_pass",   32'(ia.pass_count), 32'd0);
        chk("rst_fail",   32'(ia.fail_count), 32'd0);
        chk("rst_any",    32'(ia.any_fail), 32'd0);
        chk("rst_ffidx",  32'(ia.first_fail_idx), 32'd0);
        chk("rst_ffseen", ia.first_fail_seen, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Basic all-pass run
        wr_a(0, 32'd0, '1, 0); wr_a(1, 32'd1, '1, 0);
        wr_a(2, 32'd2, '1, 0); wr_a(3, 32'd4, '1, 0);
        q_stream = '{32'hDEAD, 32'd0, 32'd1, 32'd2, 32'd4};
        run_a("r36", 0, 0, 1);
        chk("r36_passk", 32'(ia.pass_count), 32'd4);

        // Two mismatches, first at idx 2
        q_stream = '{32'hDEAD, 32'd0, 32'd1, 32'd3, 32'd5};
        run_a("r37", 0, 0, 1);
        chk("r37_idxk",  32'(ia.first_fail_idx), 32'd2);
        chk("r37_seenk", ia.first_fail_seen, 32'h3);

        // Masked compare; write and start in the same cycle
        wr_a(0, 32'h5, 32'h0000_FFFF, 1);
        q_stream = '{32'h1234, 32'hABCD_0005, 32'd1, 32'd2, 32'd4};
        run_a("r38", 0, 0, 0);

        // Gaps, ignored mid-run start and table write
        wr_a(0, 32'd0, '1, 0);
        q_stream = '{32'hDEAD, 32'd0, 32'd1, 32'd2, 32'd4};
        run_a("r39", 3, 1, 1);
        chk("r39_passk", 32'(ia.pass_count), 32'd4);

        // Randomized tables and streams
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DA; i++) wr_a(i, $urandom, $urandom, 0);
            q_stream = {};
            q_stream.push_back($urandom);
            for (int i = 0; i < DA; i++) begin
                case ($urandom_range(0, 2))
                    0: q_stream.push_back(m_exp[i]);
                    1: q_stream.push_back(m_exp[i] ^ (~m_mask[i] & $urandom));
                    default: q_stream.push_back($urandom);
                endcase
            end
            run_a("rnd", $urandom_range(0, 2), 0, 1);
        end

        // Reset mid-run abandons without a done pulse
        begin
            int d0;
            d0 = done_a;
            start_a();
            beat_a(32'hDEAD); beat_a(32'd0); beat_a(32'd1);
            reset = 1'b0;
            #1;
            chk("r40_busy", 32'(ia.busy), 32'd0);
            chk("r40_pass", 32'(ia.pass_count), 32'd0);
            chk("r40_any",  32'(ia.any_fail), 32'd0);
            chk("r40_seen", ia.first_fail_seen, 32'd0);
            repeat (3) @(negedge clk);
            chk("r40_nodone", 32'(done_a - d0), 32'd0);
            reset = 1'b1;
            repeat (3) @(negedge clk);
        end
        wr_a(0, 32'd0, '1, 0); wr_a(1, 32'd1, '1, 0);
        wr_a(2, 32'd2, '1, 0); wr_a(3, 32'd4, '1, 0);
        q_stream = '{32'hDEAD, 32'd0, 32'd1, 32'd2, 32'd4};
        run_a("r40b", 0, 0, 1);
        chk("r40b_passk", 32'(ia.pass_count), 32'd4);

        // SKIP=0, DEPTH=1 instance
        for (int r = 0; r < 2; r++) begin
            logic [31:0] v;
            int d0;
            v = (r == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            d0 = done_b;
            ib.exp_we = 1'b1; ib.exp_addr = 1'b0; ib.exp_data = 32'hFFFF_FFFE; ib.exp_mask = '1;
            @(negedge clk);
            ib.exp_we = 1'b0; ib.start = 1'b1;
            @(negedge clk);
            ib.start = 1'b0;
            chk("b_busy", 32'(ib.busy), 32'd1);
            ib.result_valid = 1'b1; ib.result = v;
            @(negedge clk);
            ib.result_valid = 1'b0;
            chk("b_done",   32'(ib.done), 32'd1);
            chk("b_pass",   32'(ib.pass_count), (v == 32'hFFFF_FFFE) ? 32'd1 : 32'd0);
            chk("b_fail",   32'(ib.fail_count), (v == 32'hFFFF_FFFE) ? 32'd0 : 32'd1);
            chk("b_ffseen", ib.first_fail_seen, (v == 32'hFFFF_FFFE) ? 32'd0 : v);
            @(negedge clk);
            chk("b_donelow", 32'(ib.done), 32'd0);
            @(negedge clk);
            chk("b_donecnt", 32'(done_b - d0), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
